// File: rtl/sdram_write.sv
// sdram_write -- single-burst SDRAM write engine (write-path twin of the read engine).
//
// For each accepted request it walks this sequence:
//   ACTIVE -> tRCD wait -> WRITE (word 1) -> stream the remaining words
//   -> BURST TERMINATE -> tWR wait -> PRECHARGE all -> tRP wait -> wr_end.
// The mode register is set for full-page bursts, so the burst stops only
// when BURST TERMINATE is issued.
//
// Ports
//   sys_clk        in   100 MHz controller clock
//   sys_rst        in   synchronous reset, active-high
//   init_end       in   SDRAM initialisation complete
//   wr_en          in   write request level, sampled only while idle
//   wr_addr[23:0]  in   {bank[23:22], row[21:9], col[8:0]}
//   wr_burst_len   in   words to write, 1..512 (larger values are clamped)
//   wr_data        in   write-FIFO data, valid one cycle after wr_fifo_rd_en
//   wr_fifo_rd_en  out  write-FIFO read strobe
//   wr_busy        out  request in progress
//   wr_end         out  one-cycle pulse when the whole sequence is done
//   write_cmd      out  {cs_n, ras_n, cas_n, we_n}
//   write_ba       out  bank address
//   write_addr     out  A12..A0
//   wr_sdram_en    out  DQ output enable
//   wr_sdram_data  out  DQ write data
//
// Timing parameters must be at least 1 for TWR_CLK and TRP_CLK.
// TRCD_CLK may be 0.
module sdram_write #(
    parameter int TRCD_CLK = 2,
    parameter int TWR_CLK  = 2,
    parameter int TRP_CLK  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        wr_en,
    input  logic [23:0] wr_addr,
    input  logic [9:0]  wr_burst_len,
    input  logic [15:0] wr_data,
    output logic        wr_fifo_rd_en,
    output logic        wr_busy,
    output logic        wr_end,
    output logic [3:0]  write_cmd,
    output logic [1:0]  write_ba,
    output logic [12:0] write_addr,
    output logic        wr_sdram_en,
    output logic [15:0] wr_sdram_data
);

    localparam logic [3:0] CMD_NOP    = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] CMD_WRITE  = 4'b0100;
    localparam logic [3:0] CMD_BTERM  = 4'b0110;
    localparam logic [3:0] CMD_PRE    = 4'b0010;

    localparam logic [9:0] MAX_LEN   = 10'd512;
    localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
    localparam logic [9:0] TWR_LAST  = 10'(TWR_CLK - 1);
    localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACTIVE,
        S_TRCD,
        S_WRITE,
        S_WR_DATA,
        S_TWR,
        S_PRE,
        S_TRP,
        S_END
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  len_q, len_d;
    logic [1:0]  bank_q, bank_d;
    logic [12:0] row_q, row_d;
    logic [8:0]  col_q, col_d;
    logic        accept;

    // A zero-length request is simply never accepted.
    assign accept = (state_q == S_IDLE) && wr_en && init_end && (wr_burst_len != 10'd0);

    // Request latch: address and clamped length are captured only on acceptance,
    // so the requester may change its inputs freely during the burst.
    always_comb begin
        len_d  = len_q;
        bank_d = bank_q;
        row_d  = row_q;
        col_d  = col_q;
        if (accept) begin
            len_d  = (wr_burst_len > MAX_LEN) ? MAX_LEN : wr_burst_len;
            bank_d = wr_addr[23:22];
            row_d  = wr_addr[21:9];
            col_d  = wr_addr[8:0];
        end
    end

    // Next-state logic. Wait states and the data phase share one counter that
    // restarts from zero whenever the state changes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (TRCD_CLK == 0) state_d = S_WRITE;
                else               state_d = S_TRCD;
            end
            S_TRCD: begin
                if (cnt_q == TRCD_LAST) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (len_q == 10'd1) state_d = S_TWR;
                else                state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                // Counter value c covers word c+2; word L is the last one driven.
                if (cnt_q == len_q - 10'd2) state_d = S_TWR;
            end
            S_TWR: begin
                if (cnt_q == TWR_LAST) state_d = S_PRE;
            end
            S_PRE: begin
                if (TRP_CLK <= 1) state_d = S_END;
                else              state_d = S_TRP;
            end
            S_TRP: begin
                if (cnt_q == TRP_LAST) state_d = S_END;
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cnt_d = (state_d != state_q) ? 10'd0 : cnt_q + 10'd1;
    end

    // Output decode from the registered state. The FIFO strobe runs one cycle
    // ahead of the DQ enable because FIFO data appears a cycle after the read.
    always_comb begin
        write_cmd     = CMD_NOP;
        write_ba      = 2'b11;
        write_addr    = 13'h1fff;
        wr_fifo_rd_en = 1'b0;
        wr_sdram_en   = 1'b0;
        wr_end        = 1'b0;
        case (state_q)
            S_ACTIVE: begin
                write_cmd     = CMD_ACTIVE;
                write_ba      = bank_q;
                write_addr    = row_q;
                wr_fifo_rd_en = (TRCD_CLK == 0);
            end
            S_TRCD: begin
                wr_fifo_rd_en = (cnt_q == TRCD_LAST);
            end
            S_WRITE: begin
                // A10 stays low: no auto-precharge, the burst ends with B_TERM.
                write_cmd     = CMD_WRITE;
                write_ba      = bank_q;
                write_addr    = {4'b0000, col_q};
                wr_sdram_en   = 1'b1;
                wr_fifo_rd_en = (len_q >= 10'd2);
            end
            S_WR_DATA: begin
                wr_sdram_en   = 1'b1;
                wr_fifo_rd_en = ((cnt_q + 10'd3) <= len_q);
            end
            S_TWR: begin
                if (cnt_q == 10'd0) write_cmd = CMD_BTERM;
            end
            S_PRE: begin
                write_cmd  = CMD_PRE;
                write_ba   = 2'b00;
                write_addr = 13'h0400;
            end
            S_END: begin
                wr_end = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign wr_busy       = (state_q != S_IDLE);
    assign wr_sdram_data = wr_sdram_en ? wr_data : 16'h0000;

    // State and request registers. A reset mid-burst drops straight to idle
    // without a precharge; the controller re-initialises the device instead.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 10'd0;
            len_q   <= 10'd0;
            bank_q  <= 2'b00;
            row_q   <= 13'h0000;
            col_q   <= 9'h000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

endmodule
